// File: rtl/codec_sample_scheduler_if.sv
// CODEC-side handshake and sample bus for the sample scheduler.
// master = scheduler (pops input, pushes output); slave = CODEC.
interface codec_sample_scheduler_if;
    logic        read_ready;
    logic [23:0] readdata_left;
    logic [23:0] readdata_right;
    logic        write_ready;
    logic        read;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;

    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
        output read, write, writedata_left, writedata_right
    );

    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
        input  read, write, writedata_left, writedata_right
    );
endinterface

// File: rtl/codec_sample_scheduler.sv
// Sequences CODEC read/write around a time-multiplexed moving-average filter
// over a circular history of the last TAPS stereo samples.
module codec_sample_scheduler #(
    parameter int unsigned TAPS       = 8,
    parameter int unsigned WR_TIMEOUT = 4095
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    codec_sample_scheduler_if.master codec,
    input  logic                     filt_en,
    output logic                     busy,
    output logic [15:0]              sample_count,
    output logic                     drop
);
    localparam int unsigned LogTaps = $clog2(TAPS);
    localparam int unsigned AccW    = 24 + LogTaps;
    localparam int unsigned ToW     = $clog2(WR_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StRead, StMac, StWaitWr, StWrite} state_e;

    state_e                    state_q, state_d;
    logic [LogTaps-1:0]        wp_q, wp_d;
    logic [LogTaps-1:0]        k_q, k_d;
    logic signed [AccW-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [ToW-1:0]            to_q, to_d;
    logic [23:0]               wdata_l_q, wdata_l_d, wdata_r_q, wdata_r_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      drop_q, drop_d;
    logic                      hist_we;
    logic [23:0]               hist_l_q [TAPS];
    logic [23:0]               hist_r_q [TAPS];

    logic [LogTaps-1:0]        rd_idx;
    logic [23:0]               tap_l, tap_r;
    logic signed [AccW-1:0]    tap_l_ext, tap_r_ext, sum_l, sum_r;

    // READ writes hist[wp] on its closing edge, so MAC k=0 already sees the new sample.
    assign rd_idx    = wp_q - k_q;
    assign tap_l     = hist_l_q[rd_idx];
    assign tap_r     = hist_r_q[rd_idx];
    assign tap_l_ext = {{LogTaps{tap_l[23]}}, tap_l};
    assign tap_r_ext = {{LogTaps{tap_r[23]}}, tap_r};
    assign sum_l     = acc_l_q + tap_l_ext;
    assign sum_r     = acc_r_q + tap_r_ext;

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        k_d       = k_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        to_d      = to_q;
        wdata_l_d = wdata_l_q;
        wdata_r_d = wdata_r_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        hist_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (codec.read_ready) state_d = StRead;
            end
            StRead: begin
                hist_we = 1'b1;
                k_d     = '0;
                acc_l_d = '0;
                acc_r_d = '0;
                state_d = StMac;
            end
            StMac: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                k_d     = k_q + 1'b1;
                if (k_q == LogTaps'(TAPS - 1)) begin
                    // Upper 24 bits of the final sum are the floor-divided average.
                    if (filt_en) begin
                        wdata_l_d = sum_l[AccW-1:LogTaps];
                        wdata_r_d = sum_r[AccW-1:LogTaps];
                    end else begin
                        wdata_l_d = hist_l_q[wp_q];
                        wdata_r_d = hist_r_q[wp_q];
                    end
                    wp_d    = wp_q + 1'b1;
                    to_d    = '0;
                    state_d = StWaitWr;
                end
            end
            StWaitWr: begin
                if (codec.write_ready) begin
                    state_d = StWrite;
                end else if (to_q == ToW'(WR_TIMEOUT - 1)) begin
                    drop_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StWrite: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= StIdle;
            wp_q      <= '0;
            k_q       <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            to_q      <= '0;
            wdata_l_q <= '0;
            wdata_r_q <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_l_q[i] <= '0;
                hist_r_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            k_q       <= k_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            to_q      <= to_d;
            wdata_l_q <= wdata_l_d;
            wdata_r_q <= wdata_r_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            if (hist_we) begin
                hist_l_q[wp_q] <= codec.readdata_left;
                hist_r_q[wp_q] <= codec.readdata_right;
            end
        end
    end

    // Gating with reset keeps the CODEC from popping/pushing on the edge that aborts the frame.
    assign codec.read            = (state_q == StRead) && !reset;
    assign codec.write           = (state_q == StWrite) && !reset;
    assign codec.writedata_left  = wdata_l_q;
    assign codec.writedata_right = wdata_r_q;
    assign busy                  = (state_q != StIdle);
    assign sample_count          = cnt_q;
    assign drop                  = drop_q;
endmodule

// File: tb/tb_codec_sample_scheduler.sv
// Directed plus randomized bench for codec_sample_scheduler against a
// moving-average reference computed from a plain sample history.
module tb_codec_sample_scheduler;
    localparam int Taps = 8;
    localparam int WrTo = 15;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        filt_en;
    logic        busy;
    logic [15:0] sample_count;
    logic        drop;

    codec_sample_scheduler_if cif ();

    codec_sample_scheduler #(
        .TAPS      (Taps),
        .WR_TIMEOUT(WrTo)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .codec       (cif),
        .filt_en     (filt_en),
        .busy        (busy),
        .sample_count(sample_count),
        .drop        (drop)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_read_cyc = 0;
    longint hist_l [Taps];
    longint hist_r [Taps];
    int     mwp;
    int     mcount;
    bit     mdrop;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(input longint s);
        longint q;
        q = s / Taps;
        if ((s % Taps) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Taps; i++) begin
            hist_l[i] = 0;
            hist_r[i] = 0;
        end
        mwp    = 0;
        mcount = 0;
        mdrop  = 1'b0;
    endtask

    // wr_at: WAIT_WR cycle index at which write_ready rises (>= WrTo means never in time).
    task automatic run_sample(input logic [23:0] l, input logic [23:0] r, input bit fen,
                              input int wr_at, input bit keep_rr, input int exp_period);
        int          n;
        int          stray;
        bit          wrote;
        longint      sl, sr;
        logic [23:0] el, er;
        cif.readdata_left  = l;
        cif.readdata_right = r;
        cif.read_ready     = 1'b1;
        cif.write_ready    = 1'b0;
        filt_en            = fen;
        n = 0;
        while (cif.read !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("read_pulse", cif.read, 1);
        if (exp_period > 0) check("frame_period", cyc - last_read_cyc, exp_period);
        last_read_cyc = cyc;
        if (!keep_rr) cif.read_ready = 1'b0;

        hist_l[mwp] = $signed(l);
        hist_r[mwp] = $signed(r);
        sl = 0;
        sr = 0;
        for (int i = 0; i < Taps; i++) begin
            sl += hist_l[i];
            sr += hist_r[i];
        end
        if (fen) begin
            el = 24'(fdiv(sl));
            er = 24'(fdiv(sr));
        end else begin
            el = l;
            er = r;
        end
        mwp = (mwp + 1) % Taps;

        stray = 0;
        for (int i = 0; i < Taps; i++) begin
            tick();
            if (cif.read !== 1'b0 || cif.write !== 1'b0 || busy !== 1'b1) stray++;
        end
        check("mac_quiet_busy", stray, 0);
        tick();
        check("wdata_left", cif.writedata_left, el);
        check("wdata_right", cif.writedata_right, er);

        wrote = 1'b0;
        n = 0;
        while (n < 40) begin
            if (n == wr_at) cif.write_ready = 1'b1;
            tick();
            n++;
            if (cif.write === 1'b1) begin
                wrote = 1'b1;
                break;
            end
            if (busy === 1'b0) break;
        end
        cif.write_ready = 1'b0;
        if (wr_at < WrTo) begin
            check("write_seen", wrote, 1);
            check("write_latency", n, wr_at + 1);
            check("no_read_with_write", cif.read, 0);
            mcount = (mcount + 1) & 16'hFFFF;
            tick();
            check("write_one_cycle", cif.write, 0);
            check("idle_after_write", busy, 0);
        end else begin
            check("no_write_on_timeout", wrote, 0);
            check("timeout_cycles", n, WrTo);
            mdrop = 1'b1;
        end
        check("sample_count", sample_count, mcount);
        check("drop", drop, mdrop);
    endtask

    initial begin
        int n;
        reset              = 1'b1;
        filt_en            = 1'b1;
        cif.read_ready     = 1'b0;
        cif.write_ready    = 1'b0;
        cif.readdata_left  = '0;
        cif.readdata_right = '0;
        model_reset();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_read", cif.read, 0);
        check("rst_write", cif.write, 0);
        check("rst_wdl", cif.writedata_left, 0);
        check("rst_wdr", cif.writedata_right, 0);
        check("rst_count", sample_count, 0);
        check("rst_drop", drop, 0);
        reset = 1'b0;
        tick();

        // Impulse through the window, back-to-back frames.
        for (int i = 0; i < 10; i++) begin
            run_sample((i == 0) ? 24'h000800 : 24'h000000, 24'h0, 1'b1, 0, (i < 9),
                       (i == 0) ? 0 : 12);
            if (i == 0) check("impulse_first", cif.writedata_left, 24'h000100);
            if (i == 7) check("impulse_eighth", cif.writedata_left, 24'h000100);
            if (i == 8) check("impulse_gone", cif.writedata_left, 24'h000000);
        end

        // Signed step on right, full-scale positive on left.
        for (int i = 0; i < 10; i++) begin
            run_sample(24'h7FFFFF, 24'hFFF800, 1'b1, 0, (i < 9), (i == 0) ? 0 : 12);
            if (i == 0) check("step_first_r", cif.writedata_right, 24'hFFFF00);
        end
        check("step_settled_l", cif.writedata_left, 24'h7FFFFF);
        check("step_settled_r", cif.writedata_right, 24'hFFF800);

        // Bypass, then re-enable the filter mid-stream.
        for (int i = 0; i < 4; i++) run_sample(24'h123456, 24'hABCDEF, 1'b0, 1, 1'b0, 0);
        check("bypass_l", cif.writedata_left, 24'h123456);
        check("bypass_r", cif.writedata_right, 24'hABCDEF);
        run_sample(24'h123456, 24'hABCDEF, 1'b1, 0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            run_sample(24'($urandom), 24'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
                       1'($urandom), 0);
        end

        // Write arriving on the expiry cycle wins; then a genuine stall.
        run_sample(24'h000400, 24'hFFFC00, 1'b1, WrTo - 1, 1'b0, 0);
        run_sample(24'h000200, 24'h000300, 1'b1, 100, 1'b0, 0);
        run_sample(24'h000100, 24'h000100, 1'b1, 2, 1'b0, 0);

        // Reset during READ suppresses the read pulse.
        cif.readdata_left = 24'h000500;
        cif.read_ready    = 1'b1;
        n = 0;
        while (cif.read !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("pre_reset_read", cif.read, 1);
        reset = 1'b1;
        #1;
        check("read_gated_by_reset", cif.read, 0);
        tick();
        reset = 1'b0;
        model_reset();
        tick();

        // Reset on the 4th MAC cycle.
        cif.readdata_left  = 24'h000800;
        cif.readdata_right = 24'h000800;
        n = 0;
        while (cif.read !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("mid_mac_read", cif.read, 1);
        cif.read_ready = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wdl", cif.writedata_left, 0);
        check("mid_rst_count", sample_count, 0);
        check("mid_rst_drop", drop, 0);
        check("mid_rst_write", cif.write, 0);
        reset = 1'b0;
        model_reset();
        tick();
        run_sample(24'h000800, 24'h000000, 1'b1, 0, 1'b0, 0);
        check("post_reset_impulse", cif.writedata_left, 24'h000100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/codec_sample_scheduler.md
# codec_sample_scheduler

Sequencing controller between the audio CODEC interface and the moving-average noise filter. It owns the CODEC `read`/`write` handshake and keeps a circular history of the last TAPS stereo samples. For every accepted sample it runs a time-multiplexed accumulate over the history, one tap per cycle per channel, then presents one filtered stereo result to the CODEC. It sits at top level in place of the free-running shift-register/filter logic, with the CODEC, noise injection and clock/config blocks unchanged around it.

## Interface

**Parameters**
- `TAPS`, default 8: filter length. Power of two, range 2..64.
- `WR_TIMEOUT`, default 4095: maximum cycles to wait for `write_ready` before the result is dropped.

**Ports** (clock and reset first)
- `CLOCK_50`  in  1  system clock. All logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_ready`  in  1  CODEC has a stereo input sample available. `readdata_*` is valid while this is high.
- `readdata_left`, `readdata_right`  in  24 each  input sample, two's complement.
- `write_ready`  in  1  CODEC can accept a stereo output sample.
- `filt_en`  in  1  1 = averaged output; 0 = bypass (newest raw sample is output).
- `read`  out  1  one-cycle pulse that pops the CODEC input sample.
- `write`  out  1  one-cycle pulse that pushes `writedata_*`.
- `writedata_left`, `writedata_right`  out  24 each  output sample, registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `sample_count`  out  16  count of samples written to the CODEC. Wraps at 0xFFFF → 0.
- `drop`  out  1  sticky flag: a result was discarded on write timeout. Cleared only by `reset`.

## Operation

**Reset state**
- All outputs are 0.
- History RAM (TAPS × 2 × 24) is cleared to 0.
- Write pointer `wp` = 0, FSM = IDLE.

**FSM**
- **IDLE**: if `read_ready` → READ.
- **READ**: `read`=1 for this cycle only. `readdata_*` is written to `hist[wp]`. Tap index k=0. Accumulators are cleared. → MAC.
- **MAC**: one cycle per k = 0..TAPS-1. Each cycle, `acc_ch += sext(hist[(wp-k) mod TAPS])`. Both channels accumulate in parallel.
  - The k=0 read must return the sample written in READ (write-through or forwarding is required).
  - After k=TAPS-1: load `writedata_*`, increment `wp` (mod TAPS), clear the timeout counter, → WAIT_WR.
- **WAIT_WR**: if `write_ready` → WRITE.
  - Otherwise, when the timeout counter reaches WR_TIMEOUT: set `drop`, → IDLE with no write. `writedata_*` still updates.
- **WRITE**: `write`=1 for this cycle only. `sample_count`++. → IDLE.

**Arithmetic**
- Accumulator width is 24+log2(TAPS) bits, signed.
- Filtered result = acc >>> log2(TAPS): arithmetic shift, truncation toward −∞.
- Bypass result = `hist[wp]` before the increment, i.e. the newest sample, unmodified.
- Overflow is impossible by construction.

**Boundary conditions**
- **Wrap-around**: `wp` wraps TAPS-1 → 0. The (TAPS+1)th sample overwrites the oldest entry.
- **Start-up**: cleared history means the first TAPS outputs ramp up from partial sums. This is required behaviour; no priming is done.
- **`read_ready` outside IDLE**: ignored. The CODEC FIFO buffers it and it is taken on the next IDLE.
- **`write_ready` outside WAIT_WR**: ignored.
- **Simultaneous timeout expiry and `write_ready`**: the write wins (WRITE, `drop` not set).
- **`filt_en` changes**: sampled only on the last MAC cycle.
- **`reset` mid-operation** (any state): immediate return to the reset state on that edge. No `read`/`write` pulse is emitted in that cycle, and the history is cleared.

## Timing

- Cycle 0: IDLE sees `read_ready`=1.
- Cycle 1: READ, `read`=1.
- Cycles 2..TAPS+1: MAC.
- Cycle TAPS+2: WAIT_WR. `writedata_*` is valid from this cycle.
- If `write_ready` is already high, cycle TAPS+3 is WRITE with `write`=1.
- Back in IDLE at cycle TAPS+4. Minimum sample period is TAPS+4 cycles (12 for TAPS=8), far below the 48 kHz frame.
- `read` and `write` never assert in the same cycle, and each is exactly one cycle wide.
- `writedata_*` stays stable from the WAIT_WR entry until the next WAIT_WR entry.
- `busy` is 0 only in IDLE.

## Test plan

1. **Impulse / wrap** (TAPS=8, `filt_en`=1): left input 0x000800 then 0x000000 repeatedly, `write_ready` held high.
   - Outputs: 0x000100 for 8 consecutive samples, then 0x000000.
   - `read` and `write` pulse once per sample, 12 cycles apart.
2. **Signed step**: right input constant 0xFFF800 (−2048).
   - Outputs: 0xFFFF00, 0xFFFE00, …, 0xFFF800 from the 8th sample onward.
   - Left input constant 0x7FFFFF settles at 0x7FFFFF (no overflow).
3. **Bypass**: `filt_en`=0, inputs 0x123456 / 0xABCDEF.
   - Output equals the input for each sample, with the same latency.
   - Switching `filt_en` to 1 mid-stream gives the full average on the next sample.
4. **Write stall**: hold `write_ready`=0 with WR_TIMEOUT=15.
   - FSM leaves WAIT_WR after 15 cycles; `drop`=1 and stays 1.
   - `sample_count` is unchanged and no `write` pulse occurs.
   - Repeat with `write_ready` rising exactly on the expiry cycle: the write occurs and `drop` stays 0.
5. **Reset mid-MAC**: assert `reset` on the 4th MAC cycle.
   - Next cycle: all outputs are 0 and `busy`=0.
   - A subsequent input 0x000800 produces 0x000100, proving the history was cleared.
6. **Counter wrap**: preload via 65,536 samples.
   - `sample_count` goes 0xFFFF → 0x0000 on the WRITE cycle.
   - `read_ready` held high continuously yields back-to-back 12-cycle frames with no missed or duplicated `read`.
